height_smoother: RTL and testbench
==================================

HEIGHT_SMOOTHER -- requirements
Module: height_smoother

Interface
REQ-001 Parameter DEPTH, default 4, number of height estimates averaged (power of two).
REQ-002 Parameter MAX_STEP, default 4, maximum player_y change in pixels per frame_tick.
REQ-003 Parameter TIMEOUT_FRAMES, default 30, frame_ticks without an estimate before tracking drops.
REQ-004 Parameter Y_MIN, default 16, and Y_MAX, default 457, legal player_y range.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-007 height_in  input  10  raw pitch-derived height estimate from the pitch-to-height stage.
REQ-008 height_valid  input  1  one-cycle pulse; height_in is valid in this cycle only.
REQ-009 frame_tick  input  1  one-cycle pulse per video frame.
REQ-010 player_y  output  10  smoothed, rate-limited sprite Y position.
REQ-011 target_y  output  10  current averaged target height.
REQ-012 tracking  output  1  high while the FSM is in TRACK.

Function
REQ-013 The block shall implement two FSM states, FILL and TRACK.
REQ-014 Each accepted height_valid pulse shall clamp height_in to [Y_MIN, Y_MAX] before storage.
REQ-015 The block shall store clamped samples in a DEPTH-entry circular buffer; the write pointer wraps from DEPTH-1 to 0.
REQ-016 FILL: fill_count increments per sample; on the sample making fill_count equal DEPTH, the state shall become TRACK.
REQ-017 In FILL, target_y shall hold its previous value.
REQ-018 In TRACK, target_y shall equal the sum of all DEPTH buffered entries shifted right by log2(DEPTH), truncated, updated exactly one cycle after the height_valid pulse.
REQ-019 The running sum shall be wide enough that it never overflows: 10 + log2(DEPTH) bits.
REQ-020 On each frame_tick, if player_y < target_y, player_y shall increase by min(target_y - player_y, MAX_STEP); if greater, it shall decrease symmetrically; if equal, it shall hold.
REQ-021 player_y shall never leave [Y_MIN, Y_MAX].
REQ-022 If height_valid and frame_tick coincide, the frame step shall use the target_y value from before that cycle.
REQ-023 A frame-silence counter shall clear on every height_valid and increment on every frame_tick with no height_valid in the same cycle.
REQ-024 When the silence counter reaches TIMEOUT_FRAMES, the block shall clear the buffer, fill_count, and write pointer, and set target_y to Y_MIN.
REQ-025 On that timeout, the state shall return to FILL; player_y then glides to Y_MIN at MAX_STEP per frame.
REQ-026 The silence counter shall saturate at TIMEOUT_FRAMES; the clear shall act once per timeout event.
REQ-027 height_valid arriving in the timeout cycle shall win: it is stored as the first sample of the new fill.

Reset
REQ-028 On reset low, asynchronously: state FILL, buffer and sum 0, fill_count 0, pointer 0, silence counter 0, target_y = Y_MIN, player_y = Y_MIN, tracking 0.
REQ-029 Reset asserted mid-glide or mid-fill shall discard all history; no partial average shall survive.

Structure
REQ-030 The FSM state typedef and the defaults for Y_MIN, Y_MAX, and MAX_STEP shall live in a shared pitch_game_pkg, also used by the pitch-to-height stage.
REQ-031 One sub-module, rate_limiter (current, target, step -> next), shall contain the REQ-020/021 arithmetic.

Verification
REQ-032 Reset, then pulse reset low mid-run -> player_y = 16, target_y = 16, tracking = 0 immediately, without waiting for a clock edge.
REQ-033 Four height_valid pulses with 100, 104, 108, 112 -> tracking rises after the 4th; the next cycle target_y = 106; before the 4th pulse, target_y = 16.
REQ-034 With target_y = 106 and player_y = 16, send 23 frame_ticks -> player_y steps 20, 24, ..., 104, then 106 on the 23rd tick, and stays at 106.
REQ-035 height_in = 1000 and height_in = 0 samples -> stored as 457 and 16; the average stays within range.
REQ-036 Tracking, then 30 frame_ticks with no height_valid -> on the 30th, tracking = 0 and target_y = 16; a height_valid in that same cycle is counted as fill sample 1.
REQ-037 height_valid coincident with frame_tick -> the step uses the old target_y, and the new target_y appears the following cycle.

Source files
------------

// File: rtl/pitch_game_pkg.sv
// Shared types and defaults for the pitch-game video path.
// Also used by the pitch-to-height stage.
package pitch_game_pkg;

   localparam int unsigned HeightW    = 10;
   localparam int unsigned YMinDef    = 16;
   localparam int unsigned YMaxDef    = 457;
   localparam int unsigned MaxStepDef = 4;

   typedef enum logic {
      StFill,
      StTrack
   } track_state_e;

   function automatic logic [HeightW-1:0] clamp_height(
      input logic [HeightW-1:0] h,
      input logic [HeightW-1:0] lo,
      input logic [HeightW-1:0] hi
   );
      logic [HeightW-1:0] r;
      r = h;
      if (h < lo) r = lo;
      else if (h > hi) r = hi;
      return r;
   endfunction

endpackage

// File: rtl/rate_limiter.sv
// Moves a position toward a target by at most one step.
// The result is clamped to the legal range.
module rate_limiter
   import pitch_game_pkg::*;
#(
   parameter int unsigned Y_MIN = YMinDef,
   parameter int unsigned Y_MAX = YMaxDef
) (
   input  logic [HeightW-1:0] current_y,
   input  logic [HeightW-1:0] target_y,
   input  logic [HeightW-1:0] step,
   output logic [HeightW-1:0] next_y
);

   logic [HeightW-1:0] diff;
   logic [HeightW-1:0] moved;

   // Step never exceeds the distance, so the add cannot overshoot or wrap.
   always_comb begin
      diff  = '0;
      moved = current_y;
      if (current_y < target_y) begin
         diff  = target_y - current_y;
         moved = current_y + ((diff < step) ? diff : step);
      end else if (current_y > target_y) begin
         diff  = current_y - target_y;
         moved = current_y - ((diff < step) ? diff : step);
      end
      next_y = clamp_height(moved, HeightW'(Y_MIN), HeightW'(Y_MAX));
   end

endmodule

// File: rtl/height_smoother.sv
// Averages the last DEPTH clamped height estimates and glides player_y
// toward that average at a bounded per-frame rate; drops tracking on silence.
module height_smoother
   import pitch_game_pkg::*;
#(
   parameter int unsigned DEPTH          = 4,
   parameter int unsigned MAX_STEP       = MaxStepDef,
   parameter int unsigned TIMEOUT_FRAMES = 30,
   parameter int unsigned Y_MIN          = YMinDef,
   parameter int unsigned Y_MAX          = YMaxDef
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [HeightW-1:0] height_in,
   input  logic               height_valid,
   input  logic               frame_tick,
   output logic [HeightW-1:0] player_y,
   output logic [HeightW-1:0] target_y,
   output logic               tracking
);

   localparam int unsigned ShiftW = $clog2(DEPTH);
   localparam int unsigned SumW   = HeightW + ShiftW;
   localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW   = $clog2(DEPTH + 1);
   localparam int unsigned SilW   = $clog2(TIMEOUT_FRAMES + 1);

   localparam logic [PtrW-1:0] PtrLast  = PtrW'(DEPTH - 1);
   localparam logic [CntW-1:0] FillFull = CntW'(DEPTH);
   localparam logic [SilW-1:0] SilMax   = SilW'(TIMEOUT_FRAMES);
   localparam logic [SilW-1:0] SilLast  = SilW'(TIMEOUT_FRAMES - 1);

   track_state_e       state_q, state_d;
   logic [HeightW-1:0] hist_q [DEPTH];
   logic [HeightW-1:0] hist_d [DEPTH];
   logic [SumW-1:0]    sum_q, sum_d;
   logic [PtrW-1:0]    ptr_q, ptr_d;
   logic [CntW-1:0]    fill_q, fill_d;
   logic [SilW-1:0]    silence_q, silence_d;
   logic [HeightW-1:0] target_q, target_d;
   logic [HeightW-1:0] player_q, player_d;

   logic [HeightW-1:0] clamped;
   logic [HeightW-1:0] stepped;
   logic [SumW-1:0]    avg;
   logic               timeout;

   rate_limiter #(
      .Y_MIN (Y_MIN),
      .Y_MAX (Y_MAX)
   ) u_rate_limiter (
      .current_y (player_q),
      .target_y  (target_q),
      .step      (HeightW'(MAX_STEP)),
      .next_y    (stepped)
   );

   assign clamped = clamp_height(height_in, HeightW'(Y_MIN), HeightW'(Y_MAX));

   // Fires on the tick that brings the silence count to TIMEOUT_FRAMES; the
   // count then sits saturated, so the clear happens once per silent spell.
   assign timeout = frame_tick && (silence_q == SilLast);

   always_comb begin
      state_d   = state_q;
      hist_d    = hist_q;
      sum_d     = sum_q;
      ptr_d     = ptr_q;
      fill_d    = fill_q;
      silence_d = silence_q;
      target_d  = target_q;
      player_d  = player_q;
      avg       = '0;

      if (height_valid) begin
         silence_d = '0;
      end else if (frame_tick && (silence_q != SilMax)) begin
         silence_d = silence_q + 1'b1;
      end

      // Frame step always works from the registered (old) target.
      if (frame_tick) begin
         player_d = stepped;
      end

      if (timeout) begin
         state_d  = StFill;
         hist_d   = '{default: '0};
         sum_d    = '0;
         ptr_d    = '0;
         fill_d   = '0;
         target_d = HeightW'(Y_MIN);
      end

      // Applied on top of any timeout clear so a coincident sample opens the new fill.
      if (height_valid) begin
         sum_d         = sum_d - SumW'(hist_d[ptr_d]) + SumW'(clamped);
         hist_d[ptr_d] = clamped;
         ptr_d         = (ptr_d == PtrLast) ? '0 : ptr_d + 1'b1;
         if (state_d == StFill) begin
            fill_d = fill_d + 1'b1;
            if (fill_d == FillFull) begin
               state_d = StTrack;
            end
         end
         if (state_d == StTrack) begin
            avg      = sum_d >> ShiftW;
            target_d = avg[HeightW-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StFill;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            hist_q[i] <= '0;
         end
         sum_q     <= '0;
         ptr_q     <= '0;
         fill_q    <= '0;
         silence_q <= '0;
         target_q  <= HeightW'(Y_MIN);
         player_q  <= HeightW'(Y_MIN);
      end else begin
         state_q   <= state_d;
         hist_q    <= hist_d;
         sum_q     <= sum_d;
         ptr_q     <= ptr_d;
         fill_q    <= fill_d;
         silence_q <= silence_d;
         target_q  <= target_d;
         player_q  <= player_d;
      end
   end

   assign player_y = player_q;
   assign target_y = target_q;
   assign tracking = (state_q == StTrack);

endmodule

// File: tb/tb_height_smoother.sv
// Directed and randomized bench for height_smoother against a sliding-window
// reference model of the smoothing, rate-limit and timeout behaviour.
module tb_height_smoother;

   localparam int DEPTH   = 4;
   localparam int STEP    = 4;
   localparam int TIMEOUT = 30;
   localparam int YMIN    = 16;
   localparam int YMAX    = 457;

   logic       clk;
   logic       reset;
   logic [9:0] height_in;
   logic       height_valid;
   logic       frame_tick;
   logic [9:0] player_y;
   logic [9:0] target_y;
   logic       tracking;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int samples[$];
   int m_target;
   int m_player;
   int m_track;
   int m_sil;

   height_smoother dut (
      .clk          (clk),
      .reset        (reset),
      .height_in    (height_in),
      .height_valid (height_valid),
      .frame_tick   (frame_tick),
      .player_y     (player_y),
      .target_y     (target_y),
      .tracking     (tracking)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".player_y"}, int'(player_y), m_player);
      chk({tag, ".target_y"}, int'(target_y), m_target);
      chk({tag, ".tracking"}, int'(tracking), m_track);
   endtask

   task automatic model_reset();
      samples.delete();
      m_target = YMIN;
      m_player = YMIN;
      m_track  = 0;
      m_sil    = 0;
   endtask

   task automatic model_cycle(input bit hv, input int h, input bit ft);
      int old_target;
      int d;
      int sum;
      bit tmo;
      old_target = m_target;
      tmo = ft && (m_sil == TIMEOUT - 1);
      if (hv) m_sil = 0;
      else if (ft && m_sil < TIMEOUT) m_sil++;
      if (ft) begin
         d = old_target - m_player;
         if (d > STEP) d = STEP;
         if (d < -STEP) d = -STEP;
         m_player += d;
         if (m_player < YMIN) m_player = YMIN;
         if (m_player > YMAX) m_player = YMAX;
      end
      if (tmo) begin
         samples.delete();
         m_track  = 0;
         m_target = YMIN;
      end
      if (hv) begin
         samples.push_back((h < YMIN) ? YMIN : (h > YMAX) ? YMAX : h);
         if (samples.size() > DEPTH) void'(samples.pop_front());
         if (samples.size() == DEPTH) begin
            sum = 0;
            foreach (samples[k]) sum += samples[k];
            m_track  = 1;
            m_target = sum / DEPTH;
         end
      end
   endtask

   // One clock: drive, clock, update model, compare just after the edge.
   task automatic cyc(input string tag, input bit hv, input int h, input bit ft);
      height_valid = hv;
      height_in    = 10'(h);
      frame_tick   = ft;
      @(posedge clk);
      #1;
      model_cycle(hv, h, ft);
      height_valid = 1'b0;
      frame_tick   = 1'b0;
      chk_model(tag);
   endtask

   initial begin
      height_in    = '0;
      height_valid = 1'b0;
      frame_tick   = 1'b0;
      reset        = 1'b0;
      model_reset();
      #12;
      chk_model("reset");
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Fill with 100..112
      cyc("fill1", 1, 100, 0);
      cyc("fill2", 1, 104, 0);
      cyc("fill3", 1, 108, 0);
      chk("fill.before4_target", int'(target_y), 16);
      chk("fill.before4_tracking", int'(tracking), 0);
      cyc("fill4", 1, 112, 0);
      chk("fill.track_rise", int'(tracking), 1);
      chk("fill.avg106", int'(target_y), 106);

      // Glide 16 -> 106
      for (int i = 1; i <= 23; i++) begin
         cyc("glide", 0, 0, 1);
         if (i < 23) chk("glide.step", int'(player_y), 16 + 4 * i);
      end
      chk("glide.final", int'(player_y), 106);
      cyc("glide.hold", 0, 0, 1);
      chk("glide.hold106", int'(player_y), 106);

      // Clamping of out-of-range samples
      cyc("clamp_hi", 1, 1000, 0);
      chk("clamp_hi.target", int'(target_y), 195);
      cyc("clamp_lo", 1, 0, 0);
      chk("clamp_lo.target", int'(target_y), 173);

      // Coincident sample and frame tick
      cyc("coinc", 1, 200, 1);
      chk("coinc.old_target_step", int'(player_y), 110);
      chk("coinc.new_target", int'(target_y), 196);

      // Pure timeout
      for (int i = 1; i <= TIMEOUT; i++) begin
         cyc("silence", 0, 0, 1);
         if (i == TIMEOUT - 1) chk("silence.still_tracking", int'(tracking), 1);
      end
      chk("timeout.tracking", int'(tracking), 0);
      chk("timeout.target", int'(target_y), 16);
      for (int i = 0; i < 10; i++) cyc("saturated", 0, 0, 1);

      // Refill, then timeout with a coincident sample
      cyc("refill1", 1, 50, 0);
      cyc("refill2", 1, 60, 0);
      cyc("refill3", 1, 70, 0);
      cyc("refill4", 1, 80, 0);
      chk("refill.target", int'(target_y), 65);
      for (int i = 1; i < TIMEOUT; i++) cyc("silence2", 0, 0, 1);
      cyc("tmo_win", 1, 300, 1);
      chk("tmo_win.tracking", int'(tracking), 0);
      chk("tmo_win.target", int'(target_y), 16);
      cyc("after_tmo2", 1, 300, 0);
      cyc("after_tmo3", 1, 300, 0);
      chk("after_tmo3.tracking", int'(tracking), 0);
      cyc("after_tmo4", 1, 300, 0);
      chk("after_tmo4.tracking", int'(tracking), 1);
      chk("after_tmo4.target", int'(target_y), 300);

      // Randomized traffic with a long quiet stretch
      for (int i = 0; i < 600; i++) begin
         bit quiet;
         quiet = (i >= 200) && (i < 450);
         cyc("rand", !quiet && ($urandom_range(3) == 0), int'($urandom_range(1023)),
             (quiet ? ($urandom_range(2) == 0) : ($urandom_range(5) == 0)));
      end

      // Build up state, then asynchronous reset mid-run
      cyc("pre_rst1", 1, 400, 0);
      cyc("pre_rst2", 1, 420, 0);
      for (int i = 0; i < 5; i++) cyc("pre_rst_glide", 0, 0, 1);
      reset = 1'b0;
      #1;
      model_reset();
      chk("async_rst.player_y", int'(player_y), 16);
      chk("async_rst.target_y", int'(target_y), 16);
      chk("async_rst.tracking", int'(tracking), 0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      cyc("post_rst1", 1, 200, 0);
      cyc("post_rst2", 1, 200, 0);
      cyc("post_rst3", 1, 200, 0);
      chk("post_rst.no_partial", int'(tracking), 0);
      chk("post_rst.target_held", int'(target_y), 16);
      cyc("post_rst4", 1, 200, 1);
      chk("post_rst4.target", int'(target_y), 200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
